// File: rtl/wb_commit.sv
// Write-back commit stage: merges EXU and LSU results into one registered
// commit per cycle, parking a same-cycle EXU result in a single pending slot.
module wb_commit #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [63:0]      ex_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wen,
  output logic             ex_ready,
  input  logic             ls_valid,
  input  logic [31:0]      ls_pc,
  input  logic [63:0]      ls_data,
  input  logic [4:0]       ls_rd,
  input  logic             ls_wen,
  input  logic             ls_incache,
  output logic             ls_ready,
  output logic [70:0]      sideway,
  output logic             wb_valid,
  output logic [31:0]      wb_pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [31:0]      conflict_cnt
);

  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [63:0]      pend_data_q, pend_data_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_wen_q, pend_wen_d;
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_pc_q, wb_pc_d;
  logic [70:0]      sideway_q, sideway_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [31:0]      conflict_cnt_q, conflict_cnt_d;

  // Readiness depends only on the pending slot so it never loops through *_valid.
  assign ex_ready = !pend_valid_q;
  assign ls_ready = !pend_valid_q;

  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    pend_data_d    = pend_data_q;
    pend_rd_d      = pend_rd_q;
    pend_wen_d     = pend_wen_q;
    wb_valid_d     = 1'b0;
    wb_pc_d        = wb_pc_q;
    sideway_d      = {sideway_q[70:1], 1'b0};
    conflict_cnt_d = conflict_cnt_q;

    if (pend_valid_q) begin
      wb_valid_d   = 1'b1;
      wb_pc_d      = pend_pc_q;
      sideway_d    = {1'b1, pend_data_q, pend_rd_q, pend_wen_q && (pend_rd_q != 5'd0)};
      pend_valid_d = 1'b0;
    end else if (ls_valid) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = ls_pc;
      sideway_d  = {ls_incache, ls_data, ls_rd, ls_wen && (ls_rd != 5'd0)};
      if (ex_valid) begin
        pend_valid_d   = 1'b1;
        pend_pc_d      = ex_pc;
        pend_data_d    = ex_data;
        pend_rd_d      = ex_rd;
        pend_wen_d     = ex_wen;
        conflict_cnt_d = conflict_cnt_q + 32'd1;
      end
    end else if (ex_valid) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = ex_pc;
      sideway_d  = {1'b1, ex_data, ex_rd, ex_wen && (ex_rd != 5'd0)};
    end

    retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, wb_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pend_valid_q   <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_pc_q        <= '0;
      sideway_q      <= '0;
      retire_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      wb_valid_q     <= wb_valid_d;
      wb_pc_q        <= wb_pc_d;
      sideway_q      <= sideway_d;
      retire_cnt_q   <= retire_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Pending payload is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_pc_q   <= pend_pc_d;
    pend_data_q <= pend_data_d;
    pend_rd_q   <= pend_rd_d;
    pend_wen_q  <= pend_wen_d;
  end

  assign wb_valid     = wb_valid_q;
  assign wb_pc        = wb_pc_q;
  assign sideway      = sideway_q;
  assign retire_cnt   = retire_cnt_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit; a second instance with CNT_W=4 shares the
// stimulus so the retire counter wrap can be observed.
module tb_wb_commit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_wen;
  logic [31:0] ex_pc;
  logic [63:0] ex_data;
  logic [4:0]  ex_rd;
  logic        ls_valid, ls_wen, ls_incache;
  logic [31:0] ls_pc;
  logic [63:0] ls_data;
  logic [4:0]  ls_rd;

  logic        ex_ready, ls_ready, wb_valid;
  logic [70:0] sideway;
  logic [31:0] wb_pc, conflict_cnt;
  logic [63:0] retire_cnt;

  logic        s_ex_ready, s_ls_ready, s_wb_valid;
  logic [70:0] s_sideway;
  logic [31:0] s_wb_pc, s_conflict_cnt;
  logic [3:0]  s_retire_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_retire;

  wb_commit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data(ex_data), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .ex_ready(ex_ready),
    .ls_valid(ls_valid), .ls_pc(ls_pc), .ls_data(ls_data), .ls_rd(ls_rd),
    .ls_wen(ls_wen), .ls_incache(ls_incache), .ls_ready(ls_ready),
    .sideway(sideway), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .retire_cnt(retire_cnt), .conflict_cnt(conflict_cnt)
  );

  wb_commit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data(ex_data), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .ex_ready(s_ex_ready),
    .ls_valid(ls_valid), .ls_pc(ls_pc), .ls_data(ls_data), .ls_rd(ls_rd),
    .ls_wen(ls_wen), .ls_incache(ls_incache), .ls_ready(s_ls_ready),
    .sideway(s_sideway), .wb_valid(s_wb_valid), .wb_pc(s_wb_pc),
    .retire_cnt(s_retire_cnt), .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_pc = '0; ex_data = '0; ex_rd = '0; ex_wen = 1'b0;
    ls_valid = 1'b0; ls_pc = '0; ls_data = '0; ls_rd = '0; ls_wen = 1'b0;
    ls_incache = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    // inputs presented during reset must be ignored
    ex_valid = 1'b1; ex_pc = 32'hDEAD0000; ex_rd = 5'd7; ex_wen = 1'b1;
    ls_valid = 1'b1; ls_pc = 32'hBEEF0000; ls_rd = 5'd8; ls_wen = 1'b1;
    step();
    step();
    checks++;
    if (wb_valid !== 1'b0 || sideway !== 71'd0 || wb_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: wb_valid=%b sideway=%h wb_pc=%h required 0/0/0",
               wb_valid, sideway, wb_pc);
    end
    checks++;
    if (retire_cnt !== 64'd0 || conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: retire=%0d conflict=%0d required 0/0",
               retire_cnt, conflict_cnt);
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1 || ls_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ex_ready=%b ls_ready=%b required 1/1", ex_ready, ls_ready);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0 || retire_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_inputs_ignored: wb_valid=%b retire=%0d required 0/0",
               wb_valid, retire_cnt);
    end
    exp_retire = 64'd0;
  endtask

  task automatic test_single_ex();
    logic [70:0] exp;
    ex_valid = 1'b1; ex_pc = 32'h80000000; ex_data = 64'h1234; ex_rd = 5'd5; ex_wen = 1'b1;
    step();
    idle_inputs();
    exp_retire++;
    exp = {1'b1, 64'h1234, 5'd5, 1'b1};
    checks++;
    if (wb_valid !== 1'b1 || wb_pc !== 32'h80000000 || sideway !== exp) begin
      errors++;
      $display("FAIL single_ex: wb_valid=%b wb_pc=%h sideway=%h required 1/80000000/%h",
               wb_valid, wb_pc, sideway, exp);
    end
    checks++;
    if (retire_cnt !== 64'd1) begin
      errors++;
      $display("FAIL single_ex_retire: got %0d required 1", retire_cnt);
    end
    step();
    exp = {1'b1, 64'h1234, 5'd5, 1'b0};
    checks++;
    if (wb_valid !== 1'b0 || sideway !== exp || wb_pc !== 32'h80000000) begin
      errors++;
      $display("FAIL idle_hold: wb_valid=%b sideway=%h wb_pc=%h required 0/%h/80000000",
               wb_valid, sideway, wb_pc, exp);
    end
  endtask

  task automatic test_conflict();
    logic [70:0] exp;
    ex_valid = 1'b1; ex_pc = 32'h10; ex_data = 64'hAAAA; ex_rd = 5'd3; ex_wen = 1'b1;
    ls_valid = 1'b1; ls_pc = 32'h14; ls_data = 64'hBBBB; ls_rd = 5'd4; ls_wen = 1'b1;
    ls_incache = 1'b0;
    step();
    // keep a fresh LS result asserted; it must stall, not be taken
    idle_inputs();
    ls_valid = 1'b1; ls_pc = 32'h18; ls_data = 64'hCCCC; ls_rd = 5'd6; ls_wen = 1'b1;
    ls_incache = 1'b1;
    #1;
    exp_retire++;
    exp = {1'b0, 64'hBBBB, 5'd4, 1'b1};
    checks++;
    if (wb_valid !== 1'b1 || wb_pc !== 32'h14 || sideway !== exp) begin
      errors++;
      $display("FAIL conflict_ls_first: wb_valid=%b wb_pc=%h sideway=%h required 1/14/%h",
               wb_valid, wb_pc, sideway, exp);
    end
    checks++;
    if (ex_ready !== 1'b0 || ls_ready !== 1'b0 || conflict_cnt !== 32'd1) begin
      errors++;
      $display("FAIL conflict_stall: ex_ready=%b ls_ready=%b conflict=%0d required 0/0/1",
               ex_ready, ls_ready, conflict_cnt);
    end
    step();
    exp_retire++;
    exp = {1'b1, 64'hAAAA, 5'd3, 1'b1};
    checks++;
    if (wb_valid !== 1'b1 || wb_pc !== 32'h10 || sideway !== exp || retire_cnt !== exp_retire) begin
      errors++;
      $display("FAIL conflict_ex_second: wb_pc=%h sideway=%h retire=%0d required 10/%h/%0d",
               wb_pc, sideway, retire_cnt, exp, exp_retire);
    end
    checks++;
    if (ex_ready !== 1'b1 || ls_ready !== 1'b1) begin
      errors++;
      $display("FAIL conflict_ready_back: ex_ready=%b ls_ready=%b required 1/1", ex_ready, ls_ready);
    end
    step();
    idle_inputs();
    exp_retire++;
    exp = {1'b1, 64'hCCCC, 5'd6, 1'b1};
    checks++;
    if (wb_valid !== 1'b1 || wb_pc !== 32'h18 || sideway !== exp || conflict_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stalled_ls: wb_pc=%h sideway=%h conflict=%0d required 18/%h/1",
               wb_pc, sideway, conflict_cnt, exp);
    end
    step();
  endtask

  task automatic test_rd_zero();
    ls_valid = 1'b1; ls_pc = 32'h40; ls_data = 64'hFF; ls_rd = 5'd0; ls_wen = 1'b1;
    ls_incache = 1'b1;
    step();
    idle_inputs();
    exp_retire++;
    checks++;
    if (wb_valid !== 1'b1 || sideway[0] !== 1'b0 || sideway[69:6] !== 64'hFF ||
        retire_cnt !== exp_retire) begin
      errors++;
      $display("FAIL rd_zero: wb_valid=%b wen=%b data=%h retire=%0d required 1/0/ff/%0d",
               wb_valid, sideway[0], sideway[69:6], retire_cnt, exp_retire);
    end
  endtask

  task automatic test_reset_pending();
    ex_valid = 1'b1; ex_pc = 32'h20; ex_data = 64'h5; ex_rd = 5'd9; ex_wen = 1'b1;
    ls_valid = 1'b1; ls_pc = 32'h24; ls_data = 64'h6; ls_rd = 5'd10; ls_wen = 1'b1;
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
    checks++;
    if (wb_valid !== 1'b0 || sideway !== 71'd0 || wb_pc !== 32'd0 ||
        retire_cnt !== 64'd0 || conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_pending_outputs: wb_valid=%b sideway=%h wb_pc=%h retire=%0d conflict=%0d required all 0",
               wb_valid, sideway, wb_pc, retire_cnt, conflict_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1 || ls_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_pending_ready: ex_ready=%b ls_ready=%b required 1/1", ex_ready, ls_ready);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0 || retire_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_pending_dropped: wb_valid=%b wb_pc=%h retire=%0d required 0/-/0",
               wb_valid, wb_pc, retire_cnt);
    end
    exp_retire = 64'd0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin
        ex_valid = 1'b1; ex_pc = 32'h1000 + 32'(4 * i); ex_data = 64'(i); ex_rd = 5'd1; ex_wen = 1'b1;
      end else begin
        ls_valid = 1'b1; ls_pc = 32'h1000 + 32'(4 * i); ls_data = 64'(i); ls_rd = 5'd2; ls_wen = 1'b1;
        ls_incache = 1'b1;
      end
      step();
      exp_retire++;
      checks++;
      if (wb_valid !== 1'b1 || wb_pc !== 32'h1000 + 32'(4 * i) || sideway[69:6] !== 64'(i)) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL stream_%0d: wb_valid=%b wb_pc=%h data=%h required 1/%h/%h",
                   i, wb_valid, wb_pc, sideway[69:6], 32'h1000 + 32'(4 * i), 64'(i));
      end
    end
    idle_inputs();
    step();
    checks++;
    if (retire_cnt !== 64'd100 || conflict_cnt !== 32'd0 || ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_counts: retire=%0d conflict=%0d ready=%b required 100/0/1",
               retire_cnt, conflict_cnt, ex_ready);
    end
    checks++;
    if (s_retire_cnt !== 4'd4) begin
      errors++;
      $display("FAIL stream_small_retire: got %0d required 4", s_retire_cnt);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ls_valid = 1'b1; ls_pc = 32'(i); ls_rd = 5'd0; ls_wen = 1'b0;
      step();
    end
    idle_inputs();
    step();
    checks++;
    if (s_retire_cnt !== 4'd1 || retire_cnt !== 64'd17) begin
      errors++;
      $display("FAIL counter_wrap: small=%0d wide=%0d required 1/17", s_retire_cnt, retire_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    exp_retire = 64'd0;
    test_reset();
    test_single_ex();
    test_conflict();
    test_rd_zero();
    test_reset_pending();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter CNT_W, default 64: width of the retire counter.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-high (asserted = 1, despite the name).
REQ-004 ex_valid  in  1  EXU result valid.
REQ-005 ex_pc  in  32  EXU instruction PC.
REQ-006 ex_data  in  64  EXU result.
REQ-007 ex_rd  in  5  EXU destination register.
REQ-008 ex_wen  in  1  EXU register-write request.
REQ-009 ex_ready  out  1  EXU result accepted this cycle when ex_valid&&ex_ready.
REQ-010 ls_valid  in  1  LSU result valid.
REQ-011 ls_pc  in  32  LSU instruction PC.
REQ-012 ls_data  in  64  LSU result.
REQ-013 ls_rd  in  5  LSU destination register.
REQ-014 ls_wen  in  1  LSU register-write request.
REQ-015 ls_incache  in  1  LSU access was cacheable.
REQ-016 ls_ready  out  1  LSU result accepted this cycle when ls_valid&&ls_ready.
REQ-017 sideway  out  71  registered commit bus {incache[70], data[69:6], rd[5:1], wen[0]}.
REQ-018 wb_valid  out  1  sideway/wb_pc hold a committed instruction this cycle.
REQ-019 wb_pc  out  32  PC of the committed instruction.
REQ-020 retire_cnt  out  CNT_W  count of committed instructions.
REQ-021 conflict_cnt  out  32  count of cycles where both sources were accepted together.

Function
REQ-022 Exactly one instruction committed per cycle, at most; output registered; accept-to-output latency 1 cycle.
REQ-023 One pending slot (pend_valid plus stored EX fields) holds a deferred EXU result.
REQ-024 ex_ready = ls_ready = !pend_valid (combinational, no dependence on *_valid).
REQ-025 Source selection per cycle, in priority: pending slot; else LSU if ls_valid; else EXU if ex_valid; else no commit (wb_valid=0 next cycle).
REQ-026 Both ls_valid and ex_valid accepted in the same cycle: commit LSU next cycle; EX captured into pending slot; pend_valid=1; conflict_cnt += 1.
REQ-027 pend_valid=1: commit pending next cycle; pend_valid clears; no new acceptance that cycle.
REQ-028 Committed wen = source wen && (rd != 0); rd==0 never produces wen=1.
REQ-029 incache bit: LSU source -> ls_incache; EXU or pending source -> 1.
REQ-030 When no commit: wb_valid=0, sideway wen=0; other sideway/wb_pc bits hold last values.
REQ-031 retire_cnt += 1 on each cycle wb_valid is set (both wen=0 and wen=1 commits count); wraps modulo 2^CNT_W.
REQ-032 conflict_cnt wraps modulo 2^32.
REQ-033 No result is ever dropped or duplicated; commit order is LSU before EXU for same-cycle pairs.

Reset
REQ-034 While rst_n=1 at a clock edge: wb_valid=0, sideway=0, wb_pc=0, pend_valid=0, retire_cnt=0, conflict_cnt=0.
REQ-035 ex_ready=ls_ready=1 in the first cycle after reset deasserts.
REQ-036 Reset during a pending entry discards it; no commit occurs for it.
REQ-037 Inputs are ignored in any cycle with rst_n=1.

Verification
REQ-038 Single EX: ex_valid=1, pc=0x80000000, data=0x1234, rd=5, wen=1 -> next cycle wb_valid=1, wb_pc=0x80000000, sideway={1,0x1234,5,1}, retire_cnt=1.
REQ-039 Simultaneous: ex(pc=0x10, rd=3) and ls(pc=0x14, rd=4, incache=0) -> cycle+1 commits ls_pc=0x14 with incache=0; cycle+2 commits 0x10; ready=0 during cycle+1; conflict_cnt=1.
REQ-040 rd=0: ls_valid=1, rd=0, wen=1, data=0xFF -> wb_valid=1, sideway[0]=0, retire_cnt increments.
REQ-041 Reset mid-pending: create conflict, assert rst_n next cycle -> all outputs 0, EX entry never committed, readies=1 after release.
REQ-042 Back-to-back stream: 100 alternating EX/LS single-source results -> 100 commits in order, retire_cnt=100, conflict_cnt=0.
REQ-043 Counter wrap: CNT_W=4, 17 commits -> retire_cnt=1.
